uart_rx_pkt_ctrl: RTL and testbench

//  Packet controller behind uart_rx: consumes its byte/valid stream, frames packets
//  (SYNC, ADDR, LEN, payload, CHK), buffers the payload and, only if the checksum

---
 rtl/uart_rx_pkt_ctrl_pkg.sv | 27 ++
 rtl/uart_pkt_buf.sv | 27 ++
 rtl/uart_rx_pkt_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// Shared types and constants for the UART packet controller: FSM states,
// error codes and the default start-of-packet byte.
package uart_rx_pkt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_COMMIT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_LEN     = 2'd0,
        ERR_CHK     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: one synchronous write port, one asynchronous read port so the
// commit path sees the addressed byte in the same cycle the index changes.
module uart_pkt_buf
    import uart_rx_pkt_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IW    = idx_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind uart_rx: SYNC, ADDR, LEN, payload, CHK; commits the
// buffered payload through a ready handshake only when the XOR checksum matches.
//
//  state      | meaning
//  HUNT       | idle, waiting for SYNC
//  ADDR       | expecting base address byte
//  LEN        | expecting payload length
//  PAYLOAD    | buffering payload bytes
//  CHK        | expecting checksum byte
//  COMMIT     | writing buffer out, one byte per accept
module uart_rx_pkt_ctrl
    import uart_rx_pkt_ctrl_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 8680,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic       i_wr_ready,
    output logic       o_busy,
    output logic       o_pkt_ok,
    output logic       o_pkt_err,
    output logic [1:0] o_err_code
);

    localparam int IW = idx_width(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  addr_q, len_q, idx_q, k_q, csum_q;
    logic [TW-1:0] tmr_q;
    logic        wr_en_q, pkt_ok_q, pkt_err_q;
    err_code_t   err_q;
    logic [7:0]  rd_data;
    logic        buf_we, timed;

    assign buf_we = (state_q == ST_PAYLOAD) && i_data_valid;
    assign timed  = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

    uart_pkt_buf #(.DEPTH(MAX_LEN), .IW(IW)) u_buf (
        .clk_i   (i_clk),
        .we_i    (buf_we),
        .waddr_i (idx_q[IW-1:0]),
        .wdata_i (i_data),
        .raddr_i (k_q[IW-1:0]),
        .rdata_o (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_HUNT;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            k_q       <= '0;
            csum_q    <= '0;
            tmr_q     <= '0;
            wr_en_q   <= 1'b0;
            pkt_ok_q  <= 1'b0;
            pkt_err_q <= 1'b0;
            err_q     <= ERR_LEN;
        end else begin
            pkt_ok_q  <= 1'b0;
            pkt_err_q <= 1'b0;

            // Inter-byte timer: a byte always wins over a coincident expiry.
            if (timed) begin
                if (i_data_valid) begin
                    tmr_q <= TMR_LOAD;
                end else if (tmr_q == '0) begin
                    pkt_err_q <= 1'b1;
                    err_q     <= ERR_TIMEOUT;
                    state_q   <= ST_HUNT;
                end else begin
                    tmr_q <= tmr_q - 1'b1;
                end
            end

            case (state_q)
                ST_HUNT: begin
                    if (i_data_valid && (i_data == SYNC)) begin
                        tmr_q   <= TMR_LOAD;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (i_data_valid) begin
                        addr_q  <= i_data;
                        csum_q  <= i_data;
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_data_valid) begin
                        if ((i_data == 8'd0) || (int'(i_data) > MAX_LEN)) begin
                            pkt_err_q <= 1'b1;
                            err_q     <= ERR_LEN;
                            state_q   <= ST_HUNT;
                        end else begin
                            len_q   <= i_data;
                            csum_q  <= csum_q ^ i_data;
                            idx_q   <= '0;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (i_data_valid) begin
                        csum_q <= csum_q ^ i_data;
                        idx_q  <= idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            state_q <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (i_data_valid) begin
                        if (i_data == csum_q) begin
                            k_q     <= '0;
                            wr_en_q <= 1'b1;
                            state_q <= ST_COMMIT;
                        end else begin
                            pkt_err_q <= 1'b1;
                            err_q     <= ERR_CHK;
                            state_q   <= ST_HUNT;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (i_data_valid) begin
                        pkt_err_q <= 1'b1;
                        err_q     <= ERR_OVERRUN;
                    end
                    if (wr_en_q && i_wr_ready) begin
                        if (k_q == len_q - 8'd1) begin
                            wr_en_q  <= 1'b0;
                            pkt_ok_q <= 1'b1;
                            state_q  <= ST_HUNT;
                        end else begin
                            k_q <= k_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ST_HUNT;
            endcase
        end
    end

    // Address/data are forced to zero outside a write so idle outputs stay clean.
    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_en_q ? (addr_q + k_q) : 8'h00;
    assign o_wr_data  = wr_en_q ? rd_data : 8'h00;
    assign o_busy     = (state_q != ST_HUNT);
    assign o_pkt_ok   = pkt_ok_q;
    assign o_pkt_err  = pkt_err_q;
    assign o_err_code = err_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: packet table plus hand-written timeout,
// overrun and reset-during-commit sequences.
module tb_uart_rx_pkt_ctrl;

    localparam int TO   = 40;
    localparam int NVEC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready = 1'b1;
    logic       wr_en, busy, ok, err;
    logic [7:0] wa, wd;
    logic [1:0] code;

    always #5 clk = ~clk;

    uart_rx_pkt_ctrl #(.MAX_LEN(16), .TIMEOUT(TO), .SYNC(8'hA5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (data),
        .i_data_valid (valid),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wa),
        .o_wr_data    (wd),
        .i_wr_ready   (ready),
        .o_busy       (busy),
        .o_pkt_ok     (ok),
        .o_pkt_err    (err),
        .o_err_code   (code)
    );

    typedef struct packed {
        logic [23:0][7:0] b;
        logic [7:0]       nb;
        logic             tog;
        logic [7:0]       nw;
        logic [15:0][7:0] wa;
        logic [15:0][7:0] wd;
        logic [1:0]       nok;
        logic [1:0]       nerr;
        logic [1:0]       code;
    } vec_t;

    vec_t vecs [NVEC];

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_mode = 0;

    // Monitor: collects accepted writes and pulses, checks stall stability.
    logic [15:0] wq [$];
    int          ok_cnt = 0, err_cnt = 0, hold_seen = 0, hold_viol = 0;
    logic [1:0]  last_code = 2'd0;
    logic        stalled = 1'b0;
    logic [15:0] held = 16'h0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en && stalled) begin
                hold_seen <= hold_seen + 1;
                if ({wa, wd} != held) hold_viol <= hold_viol + 1;
            end
            stalled <= wr_en && !ready;
            held    <= {wa, wd};
            if (wr_en && ready) wq.push_back({wa, wd});
            if (ok) ok_cnt <= ok_cnt + 1;
            if (err) begin
                err_cnt   <= err_cnt + 1;
                last_code <= code;
            end
        end else begin
            stalled <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       ready = ~ready;
            2:       ready = 1'b0;
            default: ready = 1'b1;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string nm);
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            tick();
        end
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    task automatic pb(input int i, input logic [7:0] b);
        vecs[i].b[vecs[i].nb] = b;
        vecs[i].nb = vecs[i].nb + 8'd1;
    endtask

    task automatic pw(input int i, input logic [7:0] a, input logic [7:0] d);
        vecs[i].wa[vecs[i].nw] = a;
        vecs[i].wd[vecs[i].nw] = d;
        vecs[i].nw = vecs[i].nw + 8'd1;
    endtask

    task automatic exp_res(input int i, input logic [1:0] nok, input logic [1:0] nerr,
                           input logic [1:0] c);
        vecs[i].nok  = nok;
        vecs[i].nerr = nerr;
        vecs[i].code = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_w, base_ok, base_err, seen;

        for (int i = 0; i < NVEC; i++) vecs[i] = '0;
        // 0: basic good packet
        pb(0, 8'hA5); pb(0, 8'h10); pb(0, 8'h02); pb(0, 8'h11); pb(0, 8'h22); pb(0, 8'h21);
        pw(0, 8'h10, 8'h11); pw(0, 8'h11, 8'h22); exp_res(0, 1, 0, 0);
        // 1: address wrap with ready toggling
        pb(1, 8'hA5); pb(1, 8'hFF); pb(1, 8'h02); pb(1, 8'h01); pb(1, 8'h02); pb(1, 8'hFE);
        pw(1, 8'hFF, 8'h01); pw(1, 8'h00, 8'h02); exp_res(1, 1, 0, 0); vecs[1].tog = 1'b1;
        // 2: bad checksum
        pb(2, 8'hA5); pb(2, 8'h10); pb(2, 8'h02); pb(2, 8'h11); pb(2, 8'h22); pb(2, 8'h20);
        exp_res(2, 0, 1, 2'd1);
        // 3: junk before SYNC, SYNC value as payload data
        pb(3, 8'h00); pb(3, 8'h55); pb(3, 8'hA5); pb(3, 8'h20); pb(3, 8'h03);
        pb(3, 8'hA5); pb(3, 8'h00); pb(3, 8'h7F); pb(3, 8'hF9);
        pw(3, 8'h20, 8'hA5); pw(3, 8'h21, 8'h00); pw(3, 8'h22, 8'h7F); exp_res(3, 1, 0, 0);
        // 4: LEN 0
        pb(4, 8'hA5); pb(4, 8'h10); pb(4, 8'h00); exp_res(4, 0, 1, 2'd0);
        // 5: LEN = MAX_LEN+1
        pb(5, 8'hA5); pb(5, 8'h10); pb(5, 8'h11); exp_res(5, 0, 1, 2'd0);
        // 6: LEN = MAX_LEN, payload 00..0F XORs to zero so CHK = 30^10
        pb(6, 8'hA5); pb(6, 8'h30); pb(6, 8'h10);
        for (int j = 0; j < 16; j++) begin
            pb(6, 8'(j));
            pw(6, 8'(8'h30 + j), 8'(j));
        end
        pb(6, 8'h20); exp_res(6, 1, 0, 0);
        // 7: LEN = 1
        pb(7, 8'hA5); pb(7, 8'h40); pb(7, 8'h01); pb(7, 8'h5A); pb(7, 8'h1B);
        pw(7, 8'h40, 8'h5A); exp_res(7, 1, 0, 0);

        repeat (3) tick();
        @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_ok",    {31'd0, ok},    32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_addr",  {24'd0, wa},    32'd0);
        chk("rst_data",  {24'd0, wd},    32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            base_w = wq.size(); base_ok = ok_cnt; base_err = err_cnt;
            rdy_mode = vecs[i].tog ? 1 : 0;
            for (int j = 0; j < int'(vecs[i].nb); j++) send_byte(vecs[i].b[j]);
            wait_idle($sformatf("v%0d_drain", i));
            repeat (3) tick();
            chk($sformatf("v%0d_nwrites", i), 32'(wq.size() - base_w), 32'(vecs[i].nw));
            for (int k = 0; k < int'(vecs[i].nw); k++) begin
                if (base_w + k < wq.size()) begin
                    chk($sformatf("v%0d_w%0d_addr", i, k), {24'd0, wq[base_w+k][15:8]}, {24'd0, vecs[i].wa[k]});
                    chk($sformatf("v%0d_w%0d_data", i, k), {24'd0, wq[base_w+k][7:0]},  {24'd0, vecs[i].wd[k]});
                end
            end
            chk($sformatf("v%0d_ok", i),  32'(ok_cnt - base_ok),   32'(vecs[i].nok));
            chk($sformatf("v%0d_err", i), 32'(err_cnt - base_err), 32'(vecs[i].nerr));
            if (vecs[i].nerr != 0)
                chk($sformatf("v%0d_code", i), {30'd0, last_code}, {30'd0, vecs[i].code});
        end
        rdy_mode = 0;
        chk("stall_seen", {31'd0, hold_seen > 0}, 32'd1);
        chk("stall_hold", 32'(hold_viol), 32'd0);

        // Timeout after ADDR with no further bytes.
        base_w = wq.size();
        data = 8'hA5; valid = 1'b1; tick();
        data = 8'h10; tick();
        valid = 1'b0;
        seen = 0;
        for (int i = 1; i <= TO + 10; i++) begin
            tick();
            @(negedge clk);
            if (err) begin seen = i; break; end
        end
        chk("to_cycle", 32'(seen), 32'(TO));
        chk("to_code", {30'd0, code}, 32'd2);
        tick();
        chk("to_busy", {31'd0, busy}, 32'd0);

        // Byte on the expiry cycle wins and restarts the timer.
        data = 8'hA5; valid = 1'b1; tick();
        data = 8'h10; tick();
        valid = 1'b0;
        repeat (TO - 1) tick();
        data = 8'h02; valid = 1'b1; tick();
        valid = 1'b0;
        @(negedge clk);
        chk("race_err", {31'd0, err},  32'd0);
        chk("race_busy", {31'd0, busy}, 32'd1);
        seen = 0;
        for (int i = 1; i <= TO + 10; i++) begin
            tick();
            @(negedge clk);
            if (err) begin seen = i; break; end
        end
        chk("race_to_cycle", 32'(seen), 32'(TO));
        chk("race_to_code", {30'd0, code}, 32'd2);
        chk("to_nwrites", 32'(wq.size() - base_w), 32'd0);
        wait_idle("to_drain");

        // Byte during a stalled commit.
        rdy_mode = 2; tick();
        base_w = wq.size(); base_ok = ok_cnt; base_err = err_cnt;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        send_byte(8'h33);
        rdy_mode = 0;
        wait_idle("ovr_drain");
        repeat (3) tick();
        chk("ovr_nwrites", 32'(wq.size() - base_w), 32'd2);
        if (wq.size() >= base_w + 2) begin
            chk("ovr_w0", {16'd0, wq[base_w]},   32'h1011);
            chk("ovr_w1", {16'd0, wq[base_w+1]}, 32'h1122);
        end
        chk("ovr_ok", 32'(ok_cnt - base_ok), 32'd1);
        chk("ovr_err", 32'(err_cnt - base_err), 32'd1);
        chk("ovr_code", {30'd0, last_code}, 32'd3);

        // Reset in the middle of a commit.
        rdy_mode = 2; tick();
        base_w = wq.size(); base_ok = ok_cnt; base_err = err_cnt;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        @(negedge clk);
        chk("rc_wr_en_before", {31'd0, wr_en}, 32'd1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rc_wr_en_after", {31'd0, wr_en}, 32'd0);
        chk("rc_busy_after",  {31'd0, busy},  32'd0);
        rst = 1'b0;
        rdy_mode = 0;
        repeat (6) tick();
        chk("rc_nwrites", 32'(wq.size() - base_w), 32'd0);
        chk("rc_ok", 32'(ok_cnt - base_ok), 32'd0);
        chk("rc_err", 32'(err_cnt - base_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
